// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
// Shared definitions for the pipelined adder/subtractor:
//   chunk_width()   - carry-chain chunk width handled by one stage (WIDTH/STAGES)
//   width_ok()      - configuration legality, checked at elaboration by the top
//   stage_flags_t   - per-stage control/status register fields
// The partial sum and the skewed a/b operands are WIDTH-dependent, so the
// stage module declares those vectors next to this struct.
package pipe_adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit width_ok(input int width, input int stages);
        return (stages > 0) && (width > 0) && ((width % stages) == 0);
    endfunction

    // valid : stage holds a live transaction
    // carry : carry out of the chunk this stage added (carry-in of the next)
    // a_msb : sign of operand a, kept for the overflow decision at the end
    // b_msb : sign of the effective (possibly inverted) operand b
    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_flags_t;

endpackage

// File: rtl/param_pipeline_adder_if.sv
// pipe_adder_if
// Bundles the input and output handshakes of param_pipeline_adder.
//   in_valid/in_ready/in_a/in_b/in_cin/in_sub : input transaction
//   flush                                     : synchronous pipeline clear
//   out_valid/out_ready/out_sum/out_cout/out_ovf : result transaction
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer keeps valid and data steady until the transfer; ready may
// depend combinationally on the consumer's ready but never on valid.
// master: the side that supplies operands and consumes results.
// slave : the adder.
interface pipe_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, flush, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage
// One register stage of the pipelined adder. Stage K adds chunk K-1
// (bits [K*CW-1:(K-1)*CW]) of the skewed operands plus the incoming carry,
// merges that chunk into the partial sum and registers everything.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   flush       - clears the valid bit at the next edge
//   ready_next  - ready of the following stage (out_ready for the last one)
//   ready       - this stage can load this cycle
//   flags_in, sum_in, a_in, b_in - contents of the previous stage
//   flags_q, sum_q, a_q, b_q     - registered contents of this stage
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int K      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ready_next,
    output logic             ready,
    input  stage_flags_t     flags_in,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output stage_flags_t     flags_q,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q
);
    localparam int CW = chunk_width(WIDTH, STAGES);
    localparam int LO = (K - 1) * CW;

    logic [CW:0]      chunk;
    logic [WIDTH-1:0] sum_d;
    stage_flags_t     flags_d;

    // An empty stage always accepts, so bubbles are squeezed out even
    // while a later stage is stalled.
    assign ready = ready_next || !flags_q.valid;

    always_comb begin
        chunk         = {1'b0, a_in[LO +: CW]} + {1'b0, b_in[LO +: CW]}
                      + {{CW{1'b0}}, flags_in.carry};
        sum_d         = sum_in;
        sum_d[LO +: CW] = chunk[CW-1:0];
        flags_d       = flags_in;
        flags_d.carry = chunk[CW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            sum_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            if (ready) begin
                flags_q <= flags_d;
                sum_q   <= sum_d;
                a_q     <= a_in;
                b_q     <= b_in;
            end
            // Data may load during a flush; only the valid bit matters.
            if (flush) begin
                flags_q.valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/param_pipeline_adder.sv
// param_pipeline_adder
// Stallable pipelined adder/subtractor. A WIDTH-bit add is split into
// STAGES carry-chained chunks, one per register stage; the last stage is
// the output register. Operands travel unmodified (skewed) alongside the
// growing partial sum until their chunk is reached.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pipe_adder_if slave: in_* handshake, flush, out_* handshake
module param_pipeline_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    pipe_adder_if.slave bus
);
    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("param_pipeline_adder: WIDTH must be a positive multiple of STAGES");
    end

    // Index 0 is the operand side; index STAGES is the output register.
    stage_flags_t     flags [0:STAGES];
    logic [WIDTH-1:0] sum_w [0:STAGES];
    logic [WIDTH-1:0] a_w   [0:STAGES];
    logic [WIDTH-1:0] b_w   [0:STAGES];
    logic             ready_w [1:STAGES+1];
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             unused_tail;

    // Subtraction is a + ~b + 1; in_cin is ignored then.
    assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_eff = bus.in_sub ? 1'b1 : bus.in_cin;

    assign ready_w[STAGES+1] = bus.out_ready;
    assign bus.in_ready      = ready_w[1] && !bus.flush;

    assign flags[0] = '{valid: bus.in_valid && bus.in_ready,
                        carry: cin_eff,
                        a_msb: bus.in_a[WIDTH-1],
                        b_msb: b_eff[WIDTH-1]};
    assign sum_w[0] = '0;
    assign a_w[0]   = bus.in_a;
    assign b_w[0]   = b_eff;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .K     (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .ready_next(ready_w[k+1]),
            .ready     (ready_w[k]),
            .flags_in  (flags[k-1]),
            .sum_in    (sum_w[k-1]),
            .a_in      (a_w[k-1]),
            .b_in      (b_w[k-1]),
            .flags_q   (flags[k]),
            .sum_q     (sum_w[k]),
            .a_q       (a_w[k]),
            .b_q       (b_w[k])
        );
    end

    assign bus.out_valid = flags[STAGES].valid;
    assign bus.out_sum   = sum_w[STAGES];
    assign bus.out_cout  = flags[STAGES].carry;
    // Signed overflow: same-signed operands giving a result of the other sign.
    assign bus.out_ovf   = (flags[STAGES].a_msb == flags[STAGES].b_msb)
                        && (sum_w[STAGES][WIDTH-1] != flags[STAGES].a_msb);

    // The fully consumed operands leaving the last stage are not needed.
    assign unused_tail = ^{a_w[STAGES], b_w[STAGES]};
endmodule

// File: tb/tb_param_pipeline_adder.sv
// tb_param_pipeline_adder
// Directed bench for param_pipeline_adder. Main DUT is WIDTH=32/STAGES=4;
// two further instances (32/1 and 64/8) repeat the carry-wrap case.
module tb_param_pipeline_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    pipe_adder_if #(.WIDTH(32)) bus0 ();
    pipe_adder_if #(.WIDTH(32)) bus1 ();
    pipe_adder_if #(.WIDTH(64)) bus2 ();

    param_pipeline_adder #(.WIDTH(32), .STAGES(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    param_pipeline_adder #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    param_pipeline_adder #(.WIDTH(64), .STAGES(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic valid);
        bus0.in_a     = a;
        bus0.in_b     = b;
        bus0.in_cin   = cin;
        bus0.in_sub   = sub;
        bus0.in_valid = valid;
    endtask

    // One transaction through dut0 with out_ready=1: checks acceptance,
    // the 4-cycle latency and the result, then lets it drain.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub,
                           input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        bus0.out_ready = 1'b1;
        drive0(a, b, cin, sub, 1'b1);
        #1;
        check({tag, "_in_ready"}, bus0.in_ready, 1);
        cycle();
        bus0.in_valid = 1'b0;
        lat = 0;
        while (!bus0.out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_sum"}, bus0.out_sum, es);
        check({tag, "_cout"}, bus0.out_cout, ec);
        check({tag, "_ovf"}, bus0.out_ovf, eo);
        cycle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus0.in_valid = 0; bus0.in_a = 0; bus0.in_b = 0; bus0.in_cin = 0;
        bus0.in_sub = 0; bus0.flush = 0; bus0.out_ready = 1;
        bus1.in_valid = 0; bus1.in_a = 0; bus1.in_b = 0; bus1.in_cin = 0;
        bus1.in_sub = 0; bus1.flush = 0; bus1.out_ready = 1;
        bus2.in_valid = 0; bus2.in_a = 0; bus2.in_b = 0; bus2.in_cin = 0;
        bus2.in_sub = 0; bus2.flush = 0; bus2.out_ready = 1;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_valid0", bus0.out_valid, 0);
        check("rst_sum0", bus0.out_sum, 0);
        check("rst_cout0", bus0.out_cout, 0);
        check("rst_ovf0", bus0.out_ovf, 0);
        check("rst_valid1", bus1.out_valid, 0);
        check("rst_valid2", bus2.out_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus0.in_ready, 1);

        // Carry wrap on all three configurations, latency = STAGES
        cycle();
        bus0.in_a = 32'hFFFF_FFFF; bus0.in_b = 32'h1; bus0.in_valid = 1;
        bus1.in_a = 32'hFFFF_FFFF; bus1.in_b = 32'h1; bus1.in_valid = 1;
        bus2.in_a = 64'hFFFF_FFFF_FFFF_FFFF; bus2.in_b = 64'h1; bus2.in_valid = 1;
        #1;
        check("wrap_in_ready0", bus0.in_ready, 1);
        check("wrap_in_ready1", bus1.in_ready, 1);
        check("wrap_in_ready2", bus2.in_ready, 1);
        cycle();
        bus0.in_valid = 0; bus1.in_valid = 0; bus2.in_valid = 0;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("wrap_valid_s4_c%0d", c), bus0.out_valid, (c == 3));
            check($sformatf("wrap_valid_s1_c%0d", c), bus1.out_valid, (c == 0));
            check($sformatf("wrap_valid_s8_c%0d", c), bus2.out_valid, (c == 7));
            if (c == 3) begin
                check("wrap_sum_s4", bus0.out_sum, 0);
                check("wrap_cout_s4", bus0.out_cout, 1);
                check("wrap_ovf_s4", bus0.out_ovf, 0);
            end
            if (c == 0) begin
                check("wrap_sum_s1", bus1.out_sum, 0);
                check("wrap_cout_s1", bus1.out_cout, 1);
                check("wrap_ovf_s1", bus1.out_ovf, 0);
            end
            if (c == 7) begin
                check("wrap_sum_s8", bus2.out_sum, 0);
                check("wrap_cout_s8", bus2.out_cout, 1);
                check("wrap_ovf_s8", bus2.out_ovf, 0);
            end
            cycle();
        end

        // Subtraction (cin ignored in sub mode)
        run_one("sub_min", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_one("sub_neg", 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // 8 back-to-back adds: results 0x1002+i in 8 consecutive cycles
        bus0.out_ready = 1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive0(32'h1000 + c, 32'h1, 1'b1, 1'b0, 1'b1);
            else bus0.in_valid = 0;
            #1;
            if (c < 8) check($sformatf("b2b_in_ready_%0d", c), bus0.in_ready, 1);
            check($sformatf("b2b_valid_%0d", c), bus0.out_valid, (c >= 4 && c < 12));
            if (c >= 4 && c < 12)
                check($sformatf("b2b_sum_%0d", c - 4), bus0.out_sum, 32'h1002 + (c - 4));
            cycle();
        end

        // Stall: A parked at the output, B..D fill behind it, then drain
        bus0.out_ready = 0;
        drive0(32'h10, 32'h20, 1'b0, 1'b0, 1'b1);
        #1;
        check("stall_a_in_ready", bus0.in_ready, 1);
        cycle();
        bus0.in_valid = 0;
        cycle(); cycle(); cycle();
        check("stall_a_valid", bus0.out_valid, 1);
        check("stall_a_sum", bus0.out_sum, 32'h30);
        drive0(32'h100, 32'h1, 1'b0, 1'b1, 1'b1);
        #1;
        check("stall_b_in_ready", bus0.in_ready, 1);
        cycle();
        drive0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        #1;
        check("stall_c_in_ready", bus0.in_ready, 1);
        cycle();
        drive0(32'h3, 32'h4, 1'b1, 1'b0, 1'b1);
        #1;
        check("stall_d_in_ready", bus0.in_ready, 1);
        cycle();
        for (int c = 0; c < 3; c++) begin
            drive0(32'h9, 32'h9, 1'b0, 1'b0, 1'b1);
            #1;
            check($sformatf("full_in_ready_%0d", c), bus0.in_ready, 0);
            check($sformatf("full_valid_%0d", c), bus0.out_valid, 1);
            check($sformatf("full_hold_sum_%0d", c), bus0.out_sum, 32'h30);
            check($sformatf("full_hold_cout_%0d", c), bus0.out_cout, 0);
            cycle();
        end
        bus0.in_valid = 0;
        bus0.out_ready = 1;
        #1;
        check("drain_a_valid", bus0.out_valid, 1);
        check("drain_a_sum", bus0.out_sum, 32'h30);
        cycle();
        check("drain_b_valid", bus0.out_valid, 1);
        check("drain_b_sum", bus0.out_sum, 32'h0000_00FF);
        check("drain_b_cout", bus0.out_cout, 1);
        check("drain_b_ovf", bus0.out_ovf, 0);
        cycle();
        check("drain_c_valid", bus0.out_valid, 1);
        check("drain_c_sum", bus0.out_sum, 32'h8000_0000);
        check("drain_c_cout", bus0.out_cout, 0);
        check("drain_c_ovf", bus0.out_ovf, 1);
        cycle();
        check("drain_d_valid", bus0.out_valid, 1);
        check("drain_d_sum", bus0.out_sum, 32'h8);
        cycle();
        check("drain_empty", bus0.out_valid, 0);

        // Flush with 3 items in flight
        for (int i = 0; i < 3; i++) begin
            drive0(32'h1 + i, 32'h1, 1'b0, 1'b0, 1'b1);
            #1;
            check($sformatf("fl_in_ready_%0d", i), bus0.in_ready, 1);
            cycle();
        end
        drive0(32'h77, 32'h1, 1'b0, 1'b0, 1'b1);
        bus0.flush = 1;
        #1;
        check("flush_in_ready", bus0.in_ready, 0);
        check("flush_valid_before", bus0.out_valid, 0);
        cycle();
        bus0.flush = 0;
        bus0.in_valid = 0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("flush_valid_%0d", c), bus0.out_valid, 0);
            cycle();
        end
        run_one("post_flush", 32'h5, 32'h6, 1'b0, 1'b0, 32'hB, 1'b0, 1'b0);

        // Asynchronous reset mid-stream
        bus0.out_ready = 0;
        drive0(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        cycle();
        drive0(32'h1, 32'h1, 1'b0, 1'b0, 1'b1);
        cycle();
        bus0.in_valid = 0;
        cycle(); cycle();
        check("pre_rst_valid", bus0.out_valid, 1);
        check("pre_rst_sum", bus0.out_sum, 32'hFFFF_FFFE);
        check("pre_rst_ovf", bus0.out_ovf, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", bus0.out_valid, 0);
        check("mid_rst_sum", bus0.out_sum, 0);
        check("mid_rst_cout", bus0.out_cout, 0);
        check("mid_rst_ovf", bus0.out_ovf, 0);
        rst = 1'b0;
        bus0.out_ready = 1;
        cycle();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("after_rst_valid_%0d", c), bus0.out_valid, 0);
            cycle();
        end
        run_one("restart", 32'h2, 32'h3, 1'b0, 1'b0, 32'h5, 1'b0, 1'b0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
